drive_cmd_arbiter: RTL and testbench

// Multi-source drive-command front end between the command receivers (IR key decoder, UART rx) and Motor_ctrl_redone.

---
 rtl/drive_cmd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_drive_cmd_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_arbiter.sv
// drive_cmd_arbiter: priority arbiter for drive-command streams with key decode, watchdog auto-brake and telemetry.
// Define DRIVE_RAMP_EN to ramp duty toward the target by 1 LSB every RAMP_DIV cycles.
module drive_cmd_arbiter #(
    parameter int N_SRC = 2,
    parameter logic [N_SRC-1:0] SRC_ASCII = 2'b10,
    parameter int DUTY_W = 7,
    parameter int DUTY_INIT = 20,
    parameter int DUTY_STEP = 4,
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int TLM_PERIOD = 5_000_000,
    parameter int RAMP_DIV = 50_000,
    localparam int AW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    output logic [N_SRC-1:0]     src_ready,
    input  logic [8*N_SRC-1:0]   src_code,
    input  logic [7:0]           prox,
    output logic [2:0]           motor_stat,
    output logic [DUTY_W-1:0]    duty,
    output logic [AW-1:0]        active_src,
    output logic                 timeout,
    output logic                 tlm_valid,
    input  logic                 tlm_ready,
    output logic [7:0]           tlm_byte
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int TP_W = $clog2(TLM_PERIOD + 1);
    localparam logic [DUTY_W:0] DMAX = {1'b0, {DUTY_W{1'b1}}};
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(DUTY_STEP);

    typedef enum logic [1:0] {IDLE, RUN, TOUT} state_t;

    state_t state_q, state_d;
    logic [2:0] stat_q, stat_d;
    logic [AW-1:0] src_q, src_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [TP_W-1:0] tp_q, tp_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic tv_q, tv_d, pend_q, pend_d;
    logic [7:0] tb_q, tb_d;

    logic [N_SRC-1:0] grant;
    logic acc, acc_ascii, is_motion, is_speed, is_up, tlm_event;
    logic [AW-1:0] acc_idx;
    logic [7:0] acc_code, ir;
    logic [2:0] cmd_stat;
    logic [DUTY_W:0] up_sum;
    logic [3:0] prox_sat;

    function automatic logic [7:0] to_ir(input logic [7:0] c);
        case (c)
            8'h77: return 8'h02;
            8'h61: return 8'h04;
            8'h20: return 8'h05;
            8'h64: return 8'h06;
            8'h73: return 8'h08;
            8'h2B: return 8'h01;
            8'h2D: return 8'h03;
            default: return 8'h00;
        endcase
    endfunction

    // v ^ (v-1) sets every bit up to and including the lowest valid: exactly the unblocked sources
    always_comb begin
        src_ready = rst ? '0 : src_valid ^ (src_valid - N_SRC'(1));
        grant = src_valid & src_ready;
        acc = |grant;
        acc_idx = '0;
        acc_code = '0;
        acc_ascii = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                acc_idx = AW'(i);
                acc_code = src_code[8*i +: 8];
                acc_ascii = SRC_ASCII[i];
            end
        end
        ir = acc_ascii ? to_ir(acc_code) : acc_code;
        is_speed = ir == 8'h01 || ir == 8'h03;
        is_up = ir == 8'h01;
        case (ir)
            8'h02: cmd_stat = 3'b001;
            8'h04: cmd_stat = 3'b010;
            8'h05: cmd_stat = 3'b011;
            8'h06: cmd_stat = 3'b100;
            8'h08: cmd_stat = 3'b101;
            default: cmd_stat = 3'b000;
        endcase
        is_motion = cmd_stat != 3'b000;
    end

    always_comb begin
        state_d = state_q;
        stat_d = stat_q;
        src_d = src_q;
        wd_d = wd_q;
        target_d = target_q;
        up_sum = {1'b0, target_q} + {1'b0, STEP};
        if (acc && (is_motion || is_speed)) begin
            wd_d = '0;
            src_d = acc_idx;
            state_d = (is_motion || state_q == TOUT) ? RUN : state_q;
            stat_d = is_motion ? cmd_stat : stat_q;
            if (is_speed)
                target_d = is_up ? (up_sum > DMAX ? DMAX[DUTY_W-1:0] : up_sum[DUTY_W-1:0])
                                 : (target_q >= STEP ? target_q - STEP : '0);
        end else if (state_q == RUN) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                state_d = TOUT;
                stat_d = 3'b011;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
        tp_d = (tp_q == TP_W'(TLM_PERIOD - 1)) ? '0 : tp_q + TP_W'(1);
        tlm_event = stat_d != stat_q || tp_q == TP_W'(TLM_PERIOD - 1);
        prox_sat = prox < 8'd4 ? 4'd0 : prox >= 8'd64 ? 4'd15 : prox[5:2];
        tv_d = tv_q;
        tb_d = tb_q;
        pend_d = pend_q;
        // events during a transfer coalesce into one resend that samples fresh data
        if (tv_q) begin
            tv_d = !tlm_ready;
            pend_d = pend_q || tlm_event;
        end else if (tlm_event || pend_q) begin
            tv_d = 1'b1;
            tb_d = {prox_sat, stat_d, 1'b1};
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stat_q <= 3'b000;
            src_q <= '0;
            wd_q <= '0;
            tp_q <= '0;
            target_q <= DUTY_W'(DUTY_INIT);
            tv_q <= 1'b0;
            tb_q <= 8'h01;
            pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stat_q <= stat_d;
            src_q <= src_d;
            wd_q <= wd_d;
            tp_q <= tp_d;
            target_q <= target_d;
            tv_q <= tv_d;
            tb_q <= tb_d;
            pend_q <= pend_d;
        end
    end

`ifdef DRIVE_RAMP_EN
    localparam int RD_W = $clog2(RAMP_DIV + 1);
    logic [RD_W-1:0] ramp_q, ramp_d;
    logic [DUTY_W-1:0] duty_q, duty_d;

    // braking (commanded or watchdog) freezes both the ramp timer and duty
    always_comb begin
        ramp_d = ramp_q;
        duty_d = duty_q;
        if (stat_q != 3'b011) begin
            ramp_d = (ramp_q == RD_W'(RAMP_DIV - 1)) ? '0 : ramp_q + RD_W'(1);
            if (ramp_q == RD_W'(RAMP_DIV - 1))
                duty_d = duty_q < target_q ? duty_q + DUTY_W'(1) : duty_q > target_q ? duty_q - DUTY_W'(1) : duty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
            duty_q <= DUTY_W'(DUTY_INIT);
        end else begin
            ramp_q <= ramp_d;
            duty_q <= duty_d;
        end
    end

    assign duty = duty_q;
`else
    assign duty = target_q;
`endif

    assign motor_stat = stat_q;
    assign active_src = src_q;
    assign timeout = state_q == TOUT;
    assign tlm_valid = tv_q;
    assign tlm_byte = tb_q;
endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// tb_drive_cmd_arbiter: random and directed stimulus against a command-level reference model;
// telemetry frames are queued by the model and checked by a separate monitor.
module tb_drive_cmd_arbiter;
    localparam int DUTY_W = 5, DUTY_INIT = 20, DUTY_STEP = 4, TMO_CYC = 100, TLM_P = 1000;
    localparam int DMAX = (1 << DUTY_W) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] src_valid = '0, src_ready;
    logic [15:0] src_code = '0;
    logic [7:0] prox = '0, tlm_byte;
    logic [2:0] motor_stat;
    logic [DUTY_W-1:0] duty;
    logic [0:0] active_src;
    logic timeout, tlm_valid, tlm_ready = 1'b1;

    int total = 0, bad = 0;
    int m_stat, m_target, m_src, m_mode, m_quiet, m_cyc, m_acc;
    bit m_tv, m_pend, prev_v;
    logic [7:0] m_tb, held;
    logic [7:0] exp_q[$];
    logic [7:0] ir_codes[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h00, 8'h07, 8'hFF};
    logic [7:0] as_codes[10] = '{8'h77, 8'h61, 8'h20, 8'h64, 8'h73, 8'h2B, 8'h2D, 8'h78, 8'h57, 8'h02};
    int duty_seq[6] = '{24, 28, 31, 31, 31, 31};

    drive_cmd_arbiter #(
        .N_SRC(2), .SRC_ASCII(2'b10), .DUTY_W(DUTY_W), .DUTY_INIT(DUTY_INIT),
        .DUTY_STEP(DUTY_STEP), .TIMEOUT_CYC(TMO_CYC), .TLM_PERIOD(TLM_P)
    ) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .src_code(src_code),
        .prox(prox), .motor_stat(motor_stat), .duty(duty), .active_src(active_src),
        .timeout(timeout), .tlm_valid(tlm_valid), .tlm_ready(tlm_ready), .tlm_byte(tlm_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // 1..5 = motion status value, 8 = speed up, 9 = speed down, 0 = unrecognised
    function automatic int act_of(input logic [7:0] c, input bit ascii);
        if (ascii) begin
            case (c)
                8'h77: return 1;
                8'h61: return 2;
                8'h20: return 3;
                8'h64: return 4;
                8'h73: return 5;
                8'h2B: return 8;
                8'h2D: return 9;
                default: return 0;
            endcase
        end else begin
            case (c)
                8'h02: return 1;
                8'h04: return 2;
                8'h05: return 3;
                8'h06: return 4;
                8'h08: return 5;
                8'h01: return 8;
                8'h03: return 9;
                default: return 0;
            endcase
        end
    endfunction

    function automatic int psat(input int p);
        return p < 4 ? 0 : p >= 64 ? 15 : p / 4;
    endfunction

    task automatic model_step();
        int prev, a;
        bit ev;
        m_acc = -1;
        if (rst) begin
            m_stat = 0; m_target = DUTY_INIT; m_src = 0; m_mode = 0; m_quiet = 0;
            m_cyc = 0; m_tv = 0; m_pend = 0; m_tb = 8'h01;
            return;
        end
        prev = m_stat;
        if (src_valid[0]) m_acc = 0;
        else if (src_valid[1]) m_acc = 1;
        a = (m_acc == 0) ? act_of(src_code[7:0], 1'b0) : (m_acc == 1) ? act_of(src_code[15:8], 1'b1) : 0;
        if (a != 0) begin
            m_src = m_acc;
            m_quiet = 0;
            if (a <= 5) begin
                m_stat = a;
                m_mode = 1;
            end else begin
                m_target = (a == 8) ? ((m_target + DUTY_STEP > DMAX) ? DMAX : m_target + DUTY_STEP)
                                    : ((m_target < DUTY_STEP) ? 0 : m_target - DUTY_STEP);
                if (m_mode == 2) m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_quiet++;
            if (m_quiet == TMO_CYC) begin
                m_mode = 2;
                m_stat = 3;
            end
        end
        ev = (m_stat != prev) || (m_cyc % TLM_P == TLM_P - 1);
        if (m_tv) begin
            if (tlm_ready) m_tv = 0;
            if (ev) m_pend = 1;
        end else if (ev || m_pend) begin
            m_tv = 1;
            m_pend = 0;
            m_tb = {4'(psat(int'(prox))), 3'(m_stat), 1'b1};
            exp_q.push_back(m_tb);
        end
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        int n;
        @(negedge clk);
        chk("motor_stat", int'(motor_stat), m_stat);
        chk("duty", int'(duty), m_target);
        chk("active_src", int'(active_src), m_src);
        chk("timeout", int'(timeout), int'(m_mode == 2));
        chk("tlm_valid", int'(tlm_valid), int'(m_tv));
        chk("src_ready", int'(src_ready), rst ? 0 : src_valid[0] ? 1 : 3);
        if (tlm_valid && !prev_v) begin
            n = exp_q.size();
            chk("tlm_frame_queued", int'(n > 0), 1);
            if (n > 0) chk("tlm_byte", int'(tlm_byte), int'(exp_q.pop_front()));
            held = tlm_byte;
        end else if (tlm_valid) begin
            chk("tlm_stable", int'(tlm_byte), int'(held));
        end
        prev_v = tlm_valid;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int s, input logic [7:0] c);
        int n;
        src_valid[s] = 1'b1;
        src_code[8*s +: 8] = c;
        for (n = 0; n < 20; n++) begin
            cyc(1);
            if (m_acc == s) break;
        end
        src_valid[s] = 1'b0;
        if (n == 20) chk("send_accept_wait", n, 0);
    endtask

    task automatic wait_tlm_idle();
        int n;
        tlm_ready = 1'b1;
        for (n = 0; n < 20 && tlm_valid; n++) cyc(1);
        if (n == 20) chk("tlm_idle_wait", n, 0);
    endtask

    initial begin
        int n, rises;
        logic [7:0] last;
        cyc(2);
        chk("rst_stat", int'(motor_stat), 0);
        chk("rst_duty", int'(duty), DUTY_INIT);
        chk("rst_src", int'(active_src), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_tlm_valid", int'(tlm_valid), 0);
        chk("rst_tlm_byte", int'(tlm_byte), 8'h01);
        rst = 1'b0;
        cyc(1);

        src_valid[0] = 1'b1;
        src_code[7:0] = 8'h02;
        #1 chk("ir02_ready", int'(src_ready[0]), 1);
        cyc(1);
        src_valid[0] = 1'b0;
        chk("ir02_stat", int'(motor_stat), 1);
        chk("ir02_src", int'(active_src), 0);
        chk("ir02_tlm_valid", int'(tlm_valid), 1);
        chk("ir02_tlm_stat", int'(tlm_byte[3:1]), 1);

        cyc(2);
        src_valid = 2'b11;
        src_code = {8'h73, 8'h06};
        #1 chk("both_ready", int'(src_ready), 1);
        cyc(1);
        src_valid[0] = 1'b0;
        chk("both_first_stat", int'(motor_stat), 4);
        cyc(1);
        src_valid[1] = 1'b0;
        chk("both_second_stat", int'(motor_stat), 5);
        chk("both_second_src", int'(active_src), 1);

        send(1, 8'h77);
        for (n = 1; n <= 300; n++) begin
            cyc(1);
            if (timeout) break;
        end
        chk("tmo_cycles", n, TMO_CYC);
        chk("tmo_stat", int'(motor_stat), 3);
        chk("tmo_flag", int'(timeout), 1);
        send(1, 8'h64);
        chk("tmo_exit_stat", int'(motor_stat), 4);
        chk("tmo_exit_flag", int'(timeout), 0);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(1, 8'h2B);
            chk($sformatf("speed_up_%0d", i), int'(duty), duty_seq[i]);
        end
        send(1, 8'h2D);
        chk("speed_down", int'(duty), 27);

        wait_tlm_idle();
        tlm_ready = 1'b0;
        send(0, 8'h02);
        chk("hold_first", int'(tlm_byte[3:1]), 1);
        send(0, 8'h04);
        chk("hold_second", int'(tlm_byte[3:1]), 1);
        send(0, 8'h06);
        chk("hold_third", int'(tlm_byte[3:1]), 1);
        chk("hold_valid", int'(tlm_valid), 1);
        tlm_ready = 1'b1;
        rises = 0;
        last = '0;
        for (int i = 0; i < 8; i++) begin
            n = int'(tlm_valid);
            cyc(1);
            if (tlm_valid && n == 0) begin
                rises++;
                last = tlm_byte;
            end
        end
        chk("resend_count", rises, 1);
        chk("resend_stat", int'(last[3:1]), 4);

        wait_tlm_idle();
        prox = 8'h03;
        send(0, 8'h08);
        chk("prox03", int'(tlm_byte[7:4]), 0);
        wait_tlm_idle();
        prox = 8'h28;
        send(0, 8'h02);
        chk("prox28", int'(tlm_byte[7:4]), 10);
        wait_tlm_idle();
        prox = 8'hC0;
        send(0, 8'h05);
        chk("proxC0", int'(tlm_byte[7:4]), 15);

        send(1, 8'h78);
        cyc(2);
        chk("unrec_stat", int'(motor_stat), 3);
        chk("unrec_src", int'(active_src), 0);
        chk("unrec_duty", int'(duty), 27);
        chk("unrec_tlm", int'(tlm_valid), 0);

        for (int k = 0; k < 4000; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (!src_valid[s] || m_acc == s) begin
                    if ((k % 800) < 650 && $urandom_range(0, 2) == 0) begin
                        n = $urandom_range(0, 9);
                        src_valid[s] = 1'b1;
                        src_code[8*s +: 8] = (s == 0) ? ir_codes[n] : as_codes[n];
                    end else begin
                        src_valid[s] = 1'b0;
                    end
                end
            end
            tlm_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) prox = 8'($urandom);
            rst = $urandom_range(0, 499) == 0;
            cyc(1);
        end
        rst = 1'b0;
        src_valid = '0;
        tlm_ready = 1'b1;
        cyc(10);
        chk("tlm_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL global_timeout: got time %0t, want finish earlier", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end
endmodule
